// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular-exponentiation sequencer: operand
// select codes, sequencer states and the MM operation encodings.
package rsa_pkg;

  localparam int KEY_W_DEF = 256;
  localparam int IDX_W_DEF = 8;

  localparam logic [2:0] SEL_ONE = 3'd0;
  localparam logic [2:0] SEL_M   = 3'd1;
  localparam logic [2:0] SEL_R2  = 3'd2;
  localparam logic [2:0] SEL_X   = 3'd3;
  localparam logic [2:0] SEL_MB  = 3'd4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PREP,
    ST_MBAR,
    ST_XINIT,
    ST_SCAN,
    ST_SQR,
    ST_MUL,
    ST_FINAL,
    ST_DONE
  } state_t;

  // One MM operation: operand A, operand B, destination.
  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] dst;
  } mm_op_t;

  localparam mm_op_t OP_IDLE  = mm_op_t'({SEL_ONE, SEL_ONE, SEL_ONE});
  localparam mm_op_t OP_MBAR  = mm_op_t'({SEL_M,   SEL_R2,  SEL_MB});
  localparam mm_op_t OP_XINIT = mm_op_t'({SEL_ONE, SEL_R2,  SEL_X});
  localparam mm_op_t OP_SQR   = mm_op_t'({SEL_X,   SEL_X,   SEL_X});
  localparam mm_op_t OP_MUL   = mm_op_t'({SEL_X,   SEL_MB,  SEL_X});
  localparam mm_op_t OP_FINAL = mm_op_t'({SEL_X,   SEL_ONE, SEL_X});

endpackage

// File: rtl/rsa_exp_scan.sv
// Exponent scan bookkeeping: MSB-first bit index, "a one has been seen" flag
// and the last-bit indication used to decide when to finish.
module rsa_exp_scan
  import rsa_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reload,
  input  logic             step,
  input  logic             mark_one,
  output logic [IDX_W-1:0] exp_idx,
  output logic             seen_one,
  output logic             last_bit
);

  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(KEY_W - 1);

  // The index saturates at zero; the sequencer leaves for FINAL from there.
  always_ff @(posedge clk) begin
    if (!reset) begin
      exp_idx  <= TOP_IDX;
      seen_one <= 1'b0;
    end else if (reload) begin
      exp_idx  <= TOP_IDX;
      seen_one <= 1'b0;
    end else begin
      if (step && (exp_idx != '0)) begin
        exp_idx <= exp_idx - IDX_W'(1);
      end
      if (mark_one) begin
        seen_one <= 1'b1;
      end
    end
  end

  assign last_bit = (exp_idx == '0);

endmodule

// File: rtl/rsa_modexp_seq.sv
// Left-to-right square-and-multiply sequencer for X = M^E mod N built on a
// Montgomery multiplier and an R^2 mod N precompute unit.
module rsa_modexp_seq
  import rsa_pkg::*;
#(
  parameter int KEY_W   = KEY_W_DEF,
  parameter int IDX_W   = IDX_W_DEF,
  parameter bit SKIP_LZ = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             ready,
  output logic             done,
  output logic             host_lock,
  output logic [IDX_W-1:0] exp_idx,
  input  logic             exp_bit,
  output logic             prep_start,
  input  logic             prep_done,
  output logic             mm_start,
  output logic [2:0]       mm_a_sel,
  output logic [2:0]       mm_b_sel,
  output logic [2:0]       mm_dst_sel,
  input  logic             mm_done
);

  state_t state;
  mm_op_t op_q;
  logic   start_q;
  logic   seen_one;
  logic   last_bit;
  logic   launch;
  logic   skip_bit;
  logic   mm_ack;
  logic   prep_ack;
  logic   bit_end;
  logic   scan_reload;
  logic   scan_step;
  logic   scan_mark;

  // Completions coinciding with their own start pulse are stale and dropped.
  assign launch   = start && !start_q && (state == ST_IDLE);
  assign skip_bit = SKIP_LZ && !seen_one && !exp_bit;
  assign mm_ack   = mm_done && !mm_start;
  assign prep_ack = prep_done && !prep_start;

  always_comb begin
    bit_end = 1'b0;
    case (state)
      ST_SCAN: bit_end = skip_bit;
      ST_SQR:  bit_end = mm_ack && !exp_bit;
      ST_MUL:  bit_end = mm_ack;
      default: bit_end = 1'b0;
    endcase
  end

  assign scan_reload = launch || (state == ST_DONE);
  assign scan_step   = bit_end && !last_bit;
  assign scan_mark   = (state == ST_SCAN) && exp_bit;

  rsa_exp_scan #(
    .KEY_W (KEY_W),
    .IDX_W (IDX_W)
  ) u_scan (
    .clk      (clk),
    .reset    (reset),
    .reload   (scan_reload),
    .step     (scan_step),
    .mark_one (scan_mark),
    .exp_idx  (exp_idx),
    .seen_one (seen_one),
    .last_bit (last_bit)
  );

  // Selects stay on op_q until the next operation overwrites them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      start_q    <= 1'b0;
      ready      <= 1'b1;
      host_lock  <= 1'b0;
      done       <= 1'b0;
      prep_start <= 1'b0;
      mm_start   <= 1'b0;
      op_q       <= OP_IDLE;
    end else begin
      start_q    <= start;
      prep_start <= 1'b0;
      mm_start   <= 1'b0;
      done       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (launch) begin
            state      <= ST_PREP;
            prep_start <= 1'b1;
            ready      <= 1'b0;
            host_lock  <= 1'b1;
          end
        end
        ST_PREP: begin
          if (prep_ack) begin
            state    <= ST_MBAR;
            op_q     <= OP_MBAR;
            mm_start <= 1'b1;
          end
        end
        ST_MBAR: begin
          if (mm_ack) begin
            state    <= ST_XINIT;
            op_q     <= OP_XINIT;
            mm_start <= 1'b1;
          end
        end
        ST_XINIT: begin
          if (mm_ack) begin
            state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (skip_bit) begin
            if (last_bit) begin
              state    <= ST_FINAL;
              op_q     <= OP_FINAL;
              mm_start <= 1'b1;
            end
          end else begin
            state    <= ST_SQR;
            op_q     <= OP_SQR;
            mm_start <= 1'b1;
          end
        end
        ST_SQR: begin
          if (mm_ack) begin
            if (exp_bit) begin
              state    <= ST_MUL;
              op_q     <= OP_MUL;
              mm_start <= 1'b1;
            end else if (last_bit) begin
              state    <= ST_FINAL;
              op_q     <= OP_FINAL;
              mm_start <= 1'b1;
            end else begin
              state <= ST_SCAN;
            end
          end
        end
        ST_MUL: begin
          if (mm_ack) begin
            if (last_bit) begin
              state    <= ST_FINAL;
              op_q     <= OP_FINAL;
              mm_start <= 1'b1;
            end else begin
              state <= ST_SCAN;
            end
          end
        end
        ST_FINAL: begin
          if (mm_ack) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          ready     <= 1'b1;
          host_lock <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          ready     <= 1'b1;
          host_lock <= 1'b0;
        end
      endcase
    end
  end

  assign mm_a_sel   = op_q.a;
  assign mm_b_sel   = op_q.b;
  assign mm_dst_sel = op_q.dst;

endmodule

// File: tb/tb_rsa_modexp_seq.sv
// Scoreboard bench: two sequencers (leading-zero skip on/off) driven by
// behavioural MM/prep models and checked against a square-and-multiply model.
module tb_rsa_modexp_seq;
  import rsa_pkg::*;

  localparam int KW = 8;
  localparam int IW = 3;
  localparam logic [8:0] C_MBAR  = {SEL_M, SEL_R2, SEL_MB};
  localparam logic [8:0] C_XINIT = {SEL_ONE, SEL_R2, SEL_X};
  localparam logic [8:0] C_SQR   = {SEL_X, SEL_X, SEL_X};
  localparam logic [8:0] C_MUL   = {SEL_X, SEL_MB, SEL_X};
  localparam logic [8:0] C_FINAL = {SEL_X, SEL_ONE, SEL_X};

  typedef struct packed {
    logic [31:0][8:0] ops;
    logic [7:0]       n;
    logic [7:0]       x;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic ready[2], done[2], host_lock[2], prep_start[2], prep_done[2];
  logic mm_start[2], mm_done[2], exp_bit[2];
  logic [IW-1:0] exp_idx[2];
  logic [2:0] a_sel[2], b_sel[2], d_sel[2];

  logic [7:0] e_val = 8'h00, m_val = 8'h00, n_val = 8'hC5;
  int  errors = 0, checks = 0;
  int  mm_delay = 3, prep_delay = 4, rinv = 1;
  int  regs[2][5];
  int  mm_cnt[2], prep_cnt[2], obs_n[2], obs_prep[2], done_cnt[2], start_cnt[2], tgt[2];
  bit  mm_busy[2], chk_after[2], inject_pending[2];
  bit  inject_req = 1'b0, inject_scan = 1'b0;
  logic [8:0] obs[2][32];
  exp_t q0[$], q1[$];

  always #5 clk = ~clk;

  assign exp_bit[0] = e_val[exp_idx[0]];
  assign exp_bit[1] = e_val[exp_idx[1]];

  rsa_modexp_seq #(.KEY_W(KW), .IDX_W(IW), .SKIP_LZ(1'b1)) u_skip (
    .clk(clk), .reset(reset), .start(start), .ready(ready[0]), .done(done[0]),
    .host_lock(host_lock[0]), .exp_idx(exp_idx[0]), .exp_bit(exp_bit[0]),
    .prep_start(prep_start[0]), .prep_done(prep_done[0]), .mm_start(mm_start[0]),
    .mm_a_sel(a_sel[0]), .mm_b_sel(b_sel[0]), .mm_dst_sel(d_sel[0]), .mm_done(mm_done[0]));

  rsa_modexp_seq #(.KEY_W(KW), .IDX_W(IW), .SKIP_LZ(1'b0)) u_noskip (
    .clk(clk), .reset(reset), .start(start), .ready(ready[1]), .done(done[1]),
    .host_lock(host_lock[1]), .exp_idx(exp_idx[1]), .exp_bit(exp_bit[1]),
    .prep_start(prep_start[1]), .prep_done(prep_done[1]), .mm_start(mm_start[1]),
    .mm_a_sel(a_sel[1]), .mm_b_sel(b_sel[1]), .mm_dst_sel(d_sel[1]), .mm_done(mm_done[1]));

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int modpow(input int m, input int e, input int n);
    longint r = 1 % n;
    for (int k = 0; k < e; k++) r = (r * m) % n;
    return int'(r);
  endfunction

  // Expected op list: MBAR, XINIT, then per exponent bit (MSB first) a square
  // plus a multiply for ones, leading zeros dropped when skipping; then FINAL.
  function automatic exp_t build_exp(input int e, input int m, input int n, input bit skip);
    exp_t r;
    bit started, one;
    r = '0;
    r.ops[0] = C_MBAR;
    r.ops[1] = C_XINIT;
    r.n = 8'd2;
    started = !skip;
    for (int b = KW - 1; b >= 0; b--) begin
      one = ((e >> b) & 1) != 0;
      if (one) started = 1'b1;
      if (started) begin
        r.ops[r.n] = C_SQR;
        r.n = r.n + 8'd1;
        if (one) begin
          r.ops[r.n] = C_MUL;
          r.n = r.n + 8'd1;
        end
      end
    end
    r.ops[r.n] = C_FINAL;
    r.n = r.n + 8'd1;
    r.x = 8'(modpow(m, e, n));
    return r;
  endfunction

  function automatic int mont(input int a, input int b);
    longint p = (longint'(a) * longint'(b)) % longint'(n_val);
    return int'((p * longint'(rinv)) % longint'(n_val));
  endfunction

  task automatic applyStimulus(input logic [7:0] e, input logic [7:0] m, input logic [7:0] n);
    @(negedge clk);
    e_val = e; m_val = m; n_val = n;
    for (int r = 1; r < int'(n); r++) if ((256 * r) % int'(n) == 1) rinv = r;
    for (int i = 0; i < 2; i++) begin
      regs[i][SEL_ONE] = 1;
      regs[i][SEL_M] = int'(m);
      tgt[i] = done_cnt[i] + 1;
    end
    q0.push_back(build_exp(int'(e), int'(m), int'(n), 1'b1));
    q1.push_back(build_exp(int'(e), int'(m), int'(n), 1'b0));
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_run(input int budget);
    int cyc = 0;
    while ((done_cnt[0] < tgt[0] || done_cnt[1] < tgt[1]) && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("run_completed_skip", done_cnt[0], tgt[0]);
    checkOutput("run_completed_noskip", done_cnt[1], tgt[1]);
    repeat (3) @(negedge clk);
  endtask

  task automatic compare_run(input int i);
    exp_t e;
    int bad = 0;
    if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
      checkOutput($sformatf("unexpected_done_i%0d", i), 1, 0);
      return;
    end
    e = (i == 0) ? q0.pop_front() : q1.pop_front();
    checkOutput($sformatf("op_count_i%0d", i), obs_n[i], int'(e.n));
    for (int k = 0; k < int'(e.n) && k < 32; k++) if (obs[i][k] !== e.ops[k]) bad++;
    checkOutput($sformatf("op_trace_bad_entries_i%0d", i), bad, 0);
    checkOutput($sformatf("result_x_i%0d", i), regs[i][SEL_X], int'(e.x));
    checkOutput($sformatf("prep_pulses_i%0d", i), obs_prep[i], 1);
  endtask

  // Environment: prep/MM models plus the monitor, sampled 1 time unit after each edge.
  task automatic model_step(input int i);
    logic [8:0] code;
    code = {a_sel[i], b_sel[i], d_sel[i]};
    checkOutput($sformatf("host_lock_vs_ready_i%0d", i), int'(host_lock[i]), int'(!ready[i]));
    if (chk_after[i]) begin
      chk_after[i] = 1'b0;
      checkOutput($sformatf("ready_after_done_i%0d", i), int'(ready[i]), 1);
      checkOutput($sformatf("done_width_i%0d", i), int'(done[i]), 0);
      checkOutput($sformatf("exp_idx_reload_i%0d", i), int'(exp_idx[i]), KW - 1);
    end
    prep_done[i] = 1'b0;
    if (prep_start[i]) begin
      prep_cnt[i] = prep_delay;
      obs_prep[i]++;
      obs_n[i] = 0;
    end else if (prep_cnt[i] > 0) begin
      prep_cnt[i]--;
      if (prep_cnt[i] == 0) begin
        prep_done[i] = 1'b1;
        regs[i][SEL_R2] = 65536 % int'(n_val);
      end
    end
    mm_done[i] = inject_req || inject_pending[i];
    inject_pending[i] = 1'b0;
    if (mm_start[i]) begin
      checkOutput($sformatf("mm_start_while_busy_i%0d", i), int'(mm_busy[i]), 0);
      mm_busy[i] = 1'b1;
      mm_cnt[i] = mm_delay;
      if (obs_n[i] < 32) obs[i][obs_n[i]] = code;
      obs_n[i]++;
      start_cnt[i]++;
    end else if (mm_busy[i]) begin
      mm_cnt[i]--;
      if (mm_cnt[i] == 0) begin
        mm_busy[i] = 1'b0;
        mm_done[i] = 1'b1;
        if (a_sel[i] <= 3'd4 && b_sel[i] <= 3'd4 && d_sel[i] <= 3'd4)
          regs[i][d_sel[i]] = mont(regs[i][a_sel[i]], regs[i][b_sel[i]]);
        if (code == C_XINIT && inject_scan) inject_pending[i] = 1'b1;
      end
    end
    if (done[i]) begin
      done_cnt[i]++;
      chk_after[i] = 1'b1;
      compare_run(i);
      obs_n[i] = 0;
      obs_prep[i] = 0;
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      prep_done[i] = 1'b0; mm_done[i] = 1'b0;
      mm_cnt[i] = 0; prep_cnt[i] = 0; obs_n[i] = 0; obs_prep[i] = 0;
      done_cnt[i] = 0; start_cnt[i] = 0; tgt[i] = 0;
      mm_busy[i] = 1'b0; chk_after[i] = 1'b0; inject_pending[i] = 1'b0;
      for (int r = 0; r < 5; r++) regs[i][r] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) model_step(i);
      inject_req = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base_done[2];
    int base_start[2];
    int cyc;
    logic [7:0] e, m, n;

    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("reset_ready_i%0d", i), int'(ready[i]), 1);
      checkOutput($sformatf("reset_done_i%0d", i), int'(done[i]), 0);
      checkOutput($sformatf("reset_host_lock_i%0d", i), int'(host_lock[i]), 0);
      checkOutput($sformatf("reset_prep_start_i%0d", i), int'(prep_start[i]), 0);
      checkOutput($sformatf("reset_mm_start_i%0d", i), int'(mm_start[i]), 0);
      checkOutput($sformatf("reset_exp_idx_i%0d", i), int'(exp_idx[i]), KW - 1);
      checkOutput($sformatf("reset_sels_i%0d", i), int'({a_sel[i], b_sel[i], d_sel[i]}), 0);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Directed exponents, including all-zero, all-one and a lone LSB.
    mm_delay = 3;
    applyStimulus(8'h05, 8'h1B, 8'hC5); wait_run(2000);
    applyStimulus(8'h00, 8'h3A, 8'hC5); wait_run(2000);
    applyStimulus(8'hFF, 8'h1B, 8'hC5); wait_run(2000);
    applyStimulus(8'h01, 8'h77, 8'hC5); wait_run(2000);

    for (int r = 0; r < 6; r++) begin
      mm_delay = $urandom_range(1, 5);
      prep_delay = $urandom_range(1, 6);
      n = 8'(129 + 2 * $urandom_range(0, 63));
      m = 8'($urandom % int'(n));
      e = 8'($urandom);
      applyStimulus(e, m, n);
      wait_run(2000);
    end

    // Stray completion while idle.
    mm_delay = 3; prep_delay = 4;
    for (int i = 0; i < 2; i++) begin base_done[i] = done_cnt[i]; base_start[i] = start_cnt[i]; end
    @(negedge clk); inject_req = 1'b1;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("idle_inject_mm_starts_i%0d", i), start_cnt[i], base_start[i]);
      checkOutput($sformatf("idle_inject_done_i%0d", i), done_cnt[i], base_done[i]);
      checkOutput($sformatf("idle_inject_ready_i%0d", i), int'(ready[i]), 1);
    end

    // Stray completion during the first SCAN cycle.
    inject_scan = 1'b1;
    applyStimulus(8'h05, 8'h1B, 8'hC5); wait_run(2000);
    inject_scan = 1'b0;

    // Long start level plus a second edge while busy gives one run only.
    @(negedge clk);
    e_val = 8'h80 | 8'($urandom); m_val = 8'h1B; n_val = 8'hC5;
    for (int i = 0; i < 2; i++) begin regs[i][SEL_M] = 27; tgt[i] = done_cnt[i] + 1; end
    q0.push_back(build_exp(int'(e_val), 27, 197, 1'b1));
    q1.push_back(build_exp(int'(e_val), 27, 197, 1'b0));
    start = 1'b1;
    repeat (20) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_run(2000);
    repeat (30) @(negedge clk);
    checkOutput("single_run_skip", done_cnt[0], tgt[0]);
    checkOutput("single_run_noskip", done_cnt[1], tgt[1]);
    applyStimulus(e_val, 8'h1B, 8'hC5); wait_run(2000);

    // Reset asserted in the third cycle of the first SQR wait.
    applyStimulus(8'h80 | 8'($urandom), 8'h42, 8'hC5);
    cyc = 0;
    while (!(mm_start[0] && {a_sel[0], b_sel[0], d_sel[0]} == C_SQR) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("sqr_seen_before_reset", int'(cyc < 500), 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("midreset_ready_i%0d", i), int'(ready[i]), 1);
      checkOutput($sformatf("midreset_host_lock_i%0d", i), int'(host_lock[i]), 0);
      base_done[i] = done_cnt[i];
      base_start[i] = start_cnt[i];
      obs_n[i] = 0;
      obs_prep[i] = 0;
    end
    q0.delete();
    q1.delete();
    repeat (12) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("midreset_no_done_i%0d", i), done_cnt[i], base_done[i]);
      checkOutput($sformatf("midreset_no_mm_start_i%0d", i), start_cnt[i], base_start[i]);
      checkOutput($sformatf("midreset_exp_idx_i%0d", i), int'(exp_idx[i]), KW - 1);
    end

    applyStimulus(8'($urandom), 8'h2D, 8'hC5); wait_run(2000);

    checkOutput("scoreboard_left_skip", q0.size(), 0);
    checkOutput("scoreboard_left_noskip", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
